// File: rtl/dpram_be.sv
// True dual-port RAM with per-byte write enables, selectable same-port read-during-write, optional output register.
// Latency: 1 + OUT_REG cycles from accepting edge to rdata/rvalid; collision flag always 1 cycle.
// Backpressure: none; each port accepts one access per cycle whenever en_x_i is high and reset is released.
module dpram_be #(
   parameter string INIT_FILE   = "",
   parameter int    ADDR_WIDTH  = 8,
   parameter int    DATA_WIDTH  = 32,
   parameter int    OUT_REG     = 0,
   parameter int    WRITE_FIRST = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    en_a_i,
   input  logic [DATA_WIDTH/8-1:0] we_a_i,
   input  logic [ADDR_WIDTH-1:0]   addr_a_i,
   input  logic [DATA_WIDTH-1:0]   wdata_a_i,
   output logic [DATA_WIDTH-1:0]   rdata_a_o,
   output logic                    rvalid_a_o,
   input  logic                    en_b_i,
   input  logic [DATA_WIDTH/8-1:0] we_b_i,
   input  logic [ADDR_WIDTH-1:0]   addr_b_i,
   input  logic [DATA_WIDTH-1:0]   wdata_b_i,
   output logic [DATA_WIDTH-1:0]   rdata_b_o,
   output logic                    rvalid_b_o,
   output logic                    collision_o
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Storage array; contents survive reset.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // First read stage, one set per port.
   logic [DATA_WIDTH-1:0] rdata1_a_q, rdata1_a_d;
   logic [DATA_WIDTH-1:0] rdata1_b_q, rdata1_b_d;
   logic                  rvalid1_a_q, rvalid1_b_q;
   logic                  collision_q, collision_d;

   // Byte-masked writes; port B first so port A's lanes override on a shared address.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         for (int k = 0; k < NB; k++) begin
            if (en_b_i && we_b_i[k]) begin
               mem_q[addr_b_i][8*k +: 8] <= wdata_b_i[8*k +: 8];
            end
         end
         for (int k = 0; k < NB; k++) begin
            if (en_a_i && we_a_i[k]) begin
               mem_q[addr_a_i][8*k +: 8] <= wdata_a_i[8*k +: 8];
            end
         end
      end
   end

   // Port A read word: old contents, optionally overlaid with its own write lanes.
   always_comb begin
      rdata1_a_d = rdata1_a_q;
      if (en_a_i) begin
         rdata1_a_d = mem_q[addr_a_i];
         if (WRITE_FIRST != 0) begin
            for (int k = 0; k < NB; k++) begin
               if (we_a_i[k]) begin
                  rdata1_a_d[8*k +: 8] = wdata_a_i[8*k +: 8];
               end
            end
         end
      end
   end

   // Port B read word: old contents, optionally overlaid with its own write lanes.
   always_comb begin
      rdata1_b_d = rdata1_b_q;
      if (en_b_i) begin
         rdata1_b_d = mem_q[addr_b_i];
         if (WRITE_FIRST != 0) begin
            for (int k = 0; k < NB; k++) begin
               if (we_b_i[k]) begin
                  rdata1_b_d[8*k +: 8] = wdata_b_i[8*k +: 8];
               end
            end
         end
      end
   end

   // Same-address access with at least one writer; two reads are harmless.
   always_comb begin
      collision_d = en_a_i && en_b_i && (addr_a_i == addr_b_i) && ((|we_a_i) || (|we_b_i));
   end

   // First pipeline stage and collision flag; reset drops anything in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata1_a_q  <= '0;
         rdata1_b_q  <= '0;
         rvalid1_a_q <= 1'b0;
         rvalid1_b_q <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         rdata1_a_q  <= rdata1_a_d;
         rdata1_b_q  <= rdata1_b_d;
         rvalid1_a_q <= en_a_i;
         rvalid1_b_q <= en_b_i;
         collision_q <= collision_d;
      end
   end

   assign collision_o = collision_q;

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rdata2_a_q, rdata2_b_q;
      logic                  rvalid2_a_q, rvalid2_b_q;

      // Output stage captures data only behind a valid first stage so idle cycles hold the last word.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rdata2_a_q  <= '0;
            rdata2_b_q  <= '0;
            rvalid2_a_q <= 1'b0;
            rvalid2_b_q <= 1'b0;
         end else begin
            if (rvalid1_a_q) rdata2_a_q <= rdata1_a_q;
            if (rvalid1_b_q) rdata2_b_q <= rdata1_b_q;
            rvalid2_a_q <= rvalid1_a_q;
            rvalid2_b_q <= rvalid1_b_q;
         end
      end

      assign rdata_a_o  = rdata2_a_q;
      assign rdata_b_o  = rdata2_b_q;
      assign rvalid_a_o = rvalid2_a_q;
      assign rvalid_b_o = rvalid2_b_q;
   end else begin : g_no_out_reg
      assign rdata_a_o  = rdata1_a_q;
      assign rdata_b_o  = rdata1_b_q;
      assign rvalid_a_o = rvalid1_a_q;
      assign rvalid_b_o = rvalid1_b_q;
   end

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench: u0 is read-first with latency 1, u1 is write-first with an output register (latency 2).
// Both share stimulus; outputs sampled 1 time unit after each rising edge.
// No backpressure; the bench drives one access per port per cycle at most.
module tb_dpram_be;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_a = 1'b0, en_b = 1'b0;
   logic [3:0]  we_a = '0, we_b = '0;
   logic [7:0]  addr_a = '0, addr_b = '0;
   logic [31:0] wdata_a = '0, wdata_b = '0;

   logic [31:0] rd0_a, rd0_b, rd1_a, rd1_b;
   logic        rv0_a, rv0_b, rv1_a, rv1_b, col0, col1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dpram_be #(.INIT_FILE(""), .ADDR_WIDTH(8), .DATA_WIDTH(32), .OUT_REG(0), .WRITE_FIRST(0)) u0 (
      .clk_i(clk), .rst_ni(rst_n),
      .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
      .rdata_a_o(rd0_a), .rvalid_a_o(rv0_a),
      .en_b_i(en_b), .we_b_i(we_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
      .rdata_b_o(rd0_b), .rvalid_b_o(rv0_b),
      .collision_o(col0)
   );

   dpram_be #(.INIT_FILE(""), .ADDR_WIDTH(8), .DATA_WIDTH(32), .OUT_REG(1), .WRITE_FIRST(1)) u1 (
      .clk_i(clk), .rst_ni(rst_n),
      .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
      .rdata_a_o(rd1_a), .rvalid_a_o(rv1_a),
      .en_b_i(en_b), .we_b_i(we_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
      .rdata_b_o(rd1_b), .rvalid_b_o(rv1_b),
      .collision_o(col1)
   );

   // Stimulus helpers only; all comparisons live in the test tasks.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en_a = 1'b0; we_a = '0; en_b = 1'b0; we_b = '0;
   endtask

   task automatic set_a(input logic [3:0] we, input logic [7:0] addr, input logic [31:0] wd);
      en_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
   endtask

   task automatic set_b(input logic [3:0] we, input logic [7:0] addr, input logic [31:0] wd);
      en_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
   endtask

   // Single full-word write through port A, then drain both pipelines.
   task automatic poke_a(input logic [7:0] addr, input logic [31:0] wd);
      set_a(4'hF, addr, wd);
      cyc();
      idle();
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      repeat (3) cyc();
      checks++; if (rd0_a !== 32'h0) begin errors++; $display("FAIL reset_rd0_a got %h exp 0", rd0_a); end
      checks++; if (rd0_b !== 32'h0) begin errors++; $display("FAIL reset_rd0_b got %h exp 0", rd0_b); end
      checks++; if (rd1_a !== 32'h0) begin errors++; $display("FAIL reset_rd1_a got %h exp 0", rd1_a); end
      checks++; if (rd1_b !== 32'h0) begin errors++; $display("FAIL reset_rd1_b got %h exp 0", rd1_b); end
      checks++; if ({rv0_a, rv0_b, rv1_a, rv1_b} !== 4'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0000", {rv0_a, rv0_b, rv1_a, rv1_b}); end
      checks++; if ({col0, col1} !== 2'b0) begin errors++; $display("FAIL reset_collision got %b exp 00", {col0, col1}); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_init_read();
      poke_a(8'h10, 32'hDEADBEEF);
      set_a(4'h0, 8'h10, 32'h0);
      cyc();
      idle();
      checks++; if (rd0_a !== 32'hDEADBEEF) begin errors++; $display("FAIL read_l1_data got %h exp deadbeef", rd0_a); end
      checks++; if (rv0_a !== 1'b1) begin errors++; $display("FAIL read_l1_rvalid got %b exp 1", rv0_a); end
      checks++; if (rv1_a !== 1'b0) begin errors++; $display("FAIL read_l2_early_rvalid got %b exp 0", rv1_a); end
      cyc();
      checks++; if (rd1_a !== 32'hDEADBEEF) begin errors++; $display("FAIL read_l2_data got %h exp deadbeef", rd1_a); end
      checks++; if (rv1_a !== 1'b1) begin errors++; $display("FAIL read_l2_rvalid got %b exp 1", rv1_a); end
      checks++; if (rv0_a !== 1'b0) begin errors++; $display("FAIL read_l1_pulse got %b exp 0", rv0_a); end
      checks++; if (rd0_a !== 32'hDEADBEEF) begin errors++; $display("FAIL read_l1_hold got %h exp deadbeef", rd0_a); end
      cyc();
      checks++; if (rv1_a !== 1'b0) begin errors++; $display("FAIL read_l2_pulse got %b exp 0", rv1_a); end
      checks++; if (rd1_a !== 32'hDEADBEEF) begin errors++; $display("FAIL read_l2_hold got %h exp deadbeef", rd1_a); end
   endtask

   task automatic test_byte_write();
      set_a(4'b0101, 8'h10, 32'h11223344);
      cyc();
      idle();
      checks++; if (rd0_a !== 32'hDEADBEEF) begin errors++; $display("FAIL bytewr_rf_readback got %h exp deadbeef", rd0_a); end
      cyc();
      checks++; if (rd1_a !== 32'hDE22BE44) begin errors++; $display("FAIL bytewr_wf_readback got %h exp de22be44", rd1_a); end
      set_a(4'h0, 8'h10, 32'h0);
      cyc();
      idle();
      checks++; if (rd0_a !== 32'hDE22BE44) begin errors++; $display("FAIL bytewr_read0 got %h exp de22be44", rd0_a); end
      cyc();
      checks++; if (rd1_a !== 32'hDE22BE44) begin errors++; $display("FAIL bytewr_read1 got %h exp de22be44", rd1_a); end
      cyc();
   endtask

   // Write followed immediately by a read of the same word on the next cycle.
   task automatic test_back_to_back();
      poke_a(8'h10, 32'hDEADBEEF);
      set_a(4'hF, 8'h10, 32'hCAFEF00D);
      cyc();
      set_a(4'h0, 8'h10, 32'h0);
      checks++; if (rd0_a !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_read_first got %h exp deadbeef", rd0_a); end
      cyc();
      idle();
      checks++; if (rd0_a !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_read0 got %h exp cafef00d", rd0_a); end
      checks++; if (rv0_a !== 1'b1) begin errors++; $display("FAIL b2b_rvalid0 got %b exp 1", rv0_a); end
      checks++; if (rd1_a !== 32'hCAFEF00D) begin errors++; $display("FAIL rdw_write_first got %h exp cafef00d", rd1_a); end
      checks++; if (rv1_a !== 1'b1) begin errors++; $display("FAIL b2b_rvalid1_first got %b exp 1", rv1_a); end
      cyc();
      checks++; if (rd1_a !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_read1 got %h exp cafef00d", rd1_a); end
      checks++; if (rv1_a !== 1'b1) begin errors++; $display("FAIL b2b_rvalid1_second got %b exp 1", rv1_a); end
      checks++; if (rv0_a !== 1'b0) begin errors++; $display("FAIL b2b_rvalid0_drop got %b exp 0", rv0_a); end
      cyc();
   endtask

   task automatic test_ww_collision();
      poke_a(8'h20, 32'h00000000);
      set_a(4'b0011, 8'h20, 32'hAAAAAAAA);
      set_b(4'b0110, 8'h20, 32'hBBBBBBBB);
      cyc();
      idle();
      checks++; if ({col0, col1} !== 2'b11) begin errors++; $display("FAIL ww_collision got %b exp 11", {col0, col1}); end
      cyc();
      checks++; if ({col0, col1} !== 2'b00) begin errors++; $display("FAIL ww_collision_pulse got %b exp 00", {col0, col1}); end
      cyc();
      set_a(4'h0, 8'h20, 32'h0);
      set_b(4'h0, 8'h20, 32'h0);
      cyc();
      idle();
      checks++; if (rd0_a !== 32'h00BBAAAA) begin errors++; $display("FAIL ww_merge_a got %h exp 00bbaaaa", rd0_a); end
      checks++; if (rd0_b !== 32'h00BBAAAA) begin errors++; $display("FAIL ww_merge_b got %h exp 00bbaaaa", rd0_b); end
      checks++; if ({col0, col1} !== 2'b00) begin errors++; $display("FAIL rr_no_collision got %b exp 00", {col0, col1}); end
      cyc();
      checks++; if (rd1_b !== 32'h00BBAAAA) begin errors++; $display("FAIL ww_merge_b_l2 got %h exp 00bbaaaa", rd1_b); end
      cyc();
   endtask

   task automatic test_cross_port();
      poke_a(8'h30, 32'h12345678);
      set_a(4'hF, 8'h30, 32'h00000055);
      set_b(4'h0, 8'h30, 32'h0);
      cyc();
      idle();
      checks++; if (rd0_b !== 32'h12345678) begin errors++; $display("FAIL xport_old_rf got %h exp 12345678", rd0_b); end
      checks++; if ({col0, col1} !== 2'b11) begin errors++; $display("FAIL xport_collision got %b exp 11", {col0, col1}); end
      cyc();
      checks++; if (rd1_b !== 32'h12345678) begin errors++; $display("FAIL xport_old_wf got %h exp 12345678", rd1_b); end
      checks++; if (rd1_a !== 32'h00000055) begin errors++; $display("FAIL xport_wf_own got %h exp 00000055", rd1_a); end
      set_a(4'h0, 8'h30, 32'h0);
      set_b(4'h0, 8'h30, 32'h0);
      cyc();
      idle();
      checks++; if ({col0, col1} !== 2'b00) begin errors++; $display("FAIL xport_rr_collision got %b exp 00", {col0, col1}); end
      checks++; if (rd0_b !== 32'h00000055) begin errors++; $display("FAIL xport_new_b got %h exp 00000055", rd0_b); end
      cyc();
      cyc();
   endtask

   task automatic test_reset_midstream();
      set_a(4'h0, 8'h30, 32'h0);
      cyc();
      cyc();
      checks++; if ({rv0_a, rv1_a} !== 2'b11) begin errors++; $display("FAIL mid_stream_rvalid got %b exp 11", {rv0_a, rv1_a}); end
      rst_n = 1'b0;
      #1;
      checks++; if ({rv0_a, rv1_a, col0, col1} !== 4'b0) begin errors++; $display("FAIL mid_reset_flags got %b exp 0000", {rv0_a, rv1_a, col0, col1}); end
      checks++; if ({rd0_a, rd1_a} !== 64'h0) begin errors++; $display("FAIL mid_reset_data got %h exp 0", {rd0_a, rd1_a}); end
      cyc();
      cyc();
      checks++; if ({rv0_a, rv1_a, rd0_a, rd1_a} !== 66'h0) begin errors++; $display("FAIL mid_reset_held got %h exp 0", {rv0_a, rv1_a, rd0_a, rd1_a}); end
      rst_n = 1'b1;
      #1;
      checks++; if ({rv0_a, rv1_a} !== 2'b00) begin errors++; $display("FAIL mid_no_replay got %b exp 00", {rv0_a, rv1_a}); end
      cyc();
      set_a(4'h0, 8'h10, 32'h0);
      checks++; if (rd0_a !== 32'h00000055 || rv0_a !== 1'b1) begin errors++; $display("FAIL mid_after_release got %h/%b exp 00000055/1", rd0_a, rv0_a); end
      checks++; if (rv1_a !== 1'b0) begin errors++; $display("FAIL mid_after_release_l2 got %b exp 0", rv1_a); end
      cyc();
      idle();
      checks++; if (rd0_a !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_mem_retained got %h exp cafef00d", rd0_a); end
      checks++; if (rd1_a !== 32'h00000055 || rv1_a !== 1'b1) begin errors++; $display("FAIL mid_l2_resume got %h/%b exp 00000055/1", rd1_a, rv1_a); end
      cyc();
      checks++; if (rd1_a !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_mem_retained_l2 got %h exp cafef00d", rd1_a); end
   endtask

   initial begin
      test_reset();
      test_init_read();
      test_byte_write();
      test_back_to_back();
      test_ww_collision();
      test_cross_port();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
